// File: rtl/store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: default geometry,
// the entry record and the fence FSM states.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_FENCE,
    SB_DONE
  } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match over the store buffer entries. Entries are
// scanned oldest to youngest (relative to wr_idx) so the last hit wins.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [SB_ADDR_W-1:0]  ld_addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      index
);

  logic [IDX_W-1:0] idx;

  // NOTE: every always_comb output gets a default first, otherwise paths
  // that skip an assignment infer a latch.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    // Offset DEPTH is the oldest slot (only valid when full), offset 1 the youngest.
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wr_idx - IDX_W'(i);
      if (entries[idx].valid && (entries[idx].addr == ld_addr)) begin
        hit   = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM and data_mem, with youngest-match
// load lookup and a fence drain. Define STORE_BUF_FWD_EN to forward data.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_stall,
  input  logic                     drain_req,
  output logic                     fence_done,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  sb_state_e         state;

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              port_busy;
  logic              match;
  logic [IDX_W-1:0]  match_idx;
  sb_entry_t [DEPTH-1:0] entries;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
  assign count  = wr_ptr - rd_ptr;

  // Readiness looks only at the registered fullness; a same-cycle pop never frees a slot.
  assign st_ready = !full && (state == SB_RUN);
  assign push     = st_valid && st_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = '{valid: valid_q[i], addr: addr_q[i], data: data_q[i]};
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
    .entries (entries),
    .wr_idx  (wr_idx),
    .ld_addr (ld_addr),
    .hit     (match),
    .index   (match_idx)
  );

`ifdef STORE_BUF_FWD_EN
  assign ld_hit   = ld_valid && match;
  assign ld_data  = ld_hit ? data_q[match_idx] : '0;
  assign ld_stall = 1'b0;
`else
  // Without forwarding a matching load waits; its idle port lets the buffer drain.
  logic fwd_unused;
  assign fwd_unused = ^match_idx;
  assign ld_hit     = 1'b0;
  assign ld_data    = '0;
  assign ld_stall   = ld_valid && match;
`endif

  assign port_busy   = ld_valid && !ld_stall;
  assign mem_wr_en   = !empty && !port_busy;
  assign pop         = mem_wr_en;
  assign mem_addr    = mem_wr_en ? addr_q[rd_idx] : '0;
  assign mem_wr_data = mem_wr_en ? data_q[rd_idx] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        valid_q[rd_idx] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // NOTE: the payload array has no reset; valid_q and the pointers alone
  // decide which slots are meaningful, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_idx] <= st_addr;
      data_q[wr_idx] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SB_RUN;
      fence_done <= 1'b0;
    end else begin
      fence_done <= 1'b0;
      case (state)
        SB_RUN: begin
          if (drain_req) state <= SB_FENCE;
        end
        SB_FENCE: begin
          // Stores are blocked here, so the last pop is the edge count reaches zero.
          if (empty || ((count == PTR_W'(1)) && pop)) begin
            state      <= SB_DONE;
            fence_done <= 1'b1;
          end
        end
        SB_DONE: state <= SB_RUN;
        default: state <= SB_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a per-cycle vector table for the
// streaming cases, then hand-written fence and reset sequences.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic        ld_stall;
  logic        drain_req;
  logic        fence_done;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [2:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  store_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .drain_req   (drain_req),
    .fence_done  (fence_done),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [63:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        st_ready;
    logic        wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic [2:0]  count;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        ld_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic [63:0] stv, sta, std, ldv, lda,
    input logic [63:0] rdy, wen, maddr, mdata, cnt, hit, ldd, stall);
    vec_t r;
    r.st_valid = stv[0];
    r.st_addr  = sta[31:0];
    r.st_data  = std;
    r.ld_valid = ldv[0];
    r.ld_addr  = lda[31:0];
    r.st_ready = rdy[0];
    r.wr_en    = wen[0];
    r.mem_addr = maddr[31:0];
    r.mem_data = mdata;
    r.count    = cnt[2:0];
    r.ld_hit   = hit[0];
    r.ld_data  = ldd;
    r.ld_stall = stall[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic stv, input logic [31:0] sta, input logic [63:0] std,
                       input logic ldv, input logic [31:0] lda, input logic drq);
    st_valid  = stv;
    st_addr   = sta;
    st_data   = std;
    ld_valid  = ldv;
    ld_addr   = lda;
    drain_req = drq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: single store drains the cycle after acceptance
    vecs.push_back(v(1, 'h10, 'h5, 0, 0,      1, 0, 0,    0,    0, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,   0, 0,      1, 1, 'h10, 'h5,  1, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,   0, 0,      1, 0, 0,    0,    0, 0, 0, 0));
    // 2: port held by an unrelated load, fill to full, then drain in order
    vecs.push_back(v(1, 'h40, 'hA0, 1, 'h100, 1, 0, 0,    0,    0, 0, 0, 0));
    vecs.push_back(v(1, 'h48, 'hA1, 1, 'h100, 1, 0, 0,    0,    1, 0, 0, 0));
    vecs.push_back(v(1, 'h50, 'hA2, 1, 'h100, 1, 0, 0,    0,    2, 0, 0, 0));
    vecs.push_back(v(1, 'h58, 'hA3, 1, 'h100, 1, 0, 0,    0,    3, 0, 0, 0));
    vecs.push_back(v(1, 'h60, 'hA4, 1, 'h100, 0, 0, 0,    0,    4, 0, 0, 0));
    vecs.push_back(v(1, 'h60, 'hA4, 1, 'h100, 0, 0, 0,    0,    4, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,    0, 0,     0, 1, 'h40, 'hA0, 4, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,    0, 0,     1, 1, 'h48, 'hA1, 3, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,    0, 0,     1, 1, 'h50, 'hA2, 2, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,    0, 0,     1, 1, 'h58, 'hA3, 1, 0, 0, 0));
    vecs.push_back(v(0, 0,    0,    0, 0,     1, 0, 0,    0,    0, 0, 0, 0));
    // 3/4: two stores to the same address, then a load to it
    vecs.push_back(v(1, 'h20, 'h1, 1, 'h100,  1, 0, 0,    0,    0, 0, 0, 0));
    vecs.push_back(v(1, 'h20, 'h2, 1, 'h100,  1, 0, 0,    0,    1, 0, 0, 0));
`ifdef STORE_BUF_FWD_EN
    vecs.push_back(v(0, 0, 0, 1, 'h20,        1, 0, 0,    0,    2, 1, 'h2, 0));
    vecs.push_back(v(0, 0, 0, 1, 'h20,        1, 0, 0,    0,    2, 1, 'h2, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,           1, 1, 'h20, 'h1,  2, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,           1, 1, 'h20, 'h2,  1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,           1, 0, 0,    0,    0, 0, 0, 0));
`else
    vecs.push_back(v(0, 0, 0, 1, 'h20,        1, 1, 'h20, 'h1,  2, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 'h20,        1, 1, 'h20, 'h2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 'h20,        1, 0, 0,    0,    0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,           1, 0, 0,    0,    0, 0, 0, 0));
`endif

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check("reset.st_ready",   64'(st_ready),   64'd1);
    check("reset.count",      64'(count),      64'd0);
    check("reset.mem_wr_en",  64'(mem_wr_en),  64'd0);
    check("reset.mem_addr",   64'(mem_addr),   64'd0);
    check("reset.ld_hit",     64'(ld_hit),     64'd0);
    check("reset.ld_stall",   64'(ld_stall),   64'd0);
    check("reset.fence_done", 64'(fence_done), 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st_valid, vecs[i].st_addr, vecs[i].st_data,
            vecs[i].ld_valid, vecs[i].ld_addr, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d.st_ready", i), 64'(st_ready),    64'(vecs[i].st_ready));
      check($sformatf("v%0d.wr_en", i),    64'(mem_wr_en),   64'(vecs[i].wr_en));
      check($sformatf("v%0d.mem_addr", i), 64'(mem_addr),    64'(vecs[i].mem_addr));
      check($sformatf("v%0d.mem_data", i), mem_wr_data,      vecs[i].mem_data);
      check($sformatf("v%0d.count", i),    64'(count),       64'(vecs[i].count));
      check($sformatf("v%0d.ld_hit", i),   64'(ld_hit),      64'(vecs[i].ld_hit));
      check($sformatf("v%0d.ld_data", i),  ld_data,          vecs[i].ld_data);
      check($sformatf("v%0d.ld_stall", i), 64'(ld_stall),    64'(vecs[i].ld_stall));
      step();
    end

    // 5: fence with three queued stores (wraps the ring)
    drive(1, 'h80, 'hB0, 1, 'h100, 0); step();
    drive(1, 'h88, 'hB1, 1, 'h100, 0); step();
    drive(1, 'h90, 'hB2, 1, 'h100, 0); step();
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("fence.c0.count",    64'(count),    64'd3);
    check("fence.c0.mem_addr", 64'(mem_addr), 64'h80);
    step();
    drive(1, 'hF0, 'hFF, 0, 0, 1);
    @(negedge clk);
    check("fence.c1.st_ready", 64'(st_ready), 64'd0);
    check("fence.c1.mem_addr", 64'(mem_addr), 64'h88);
    check("fence.c1.count",    64'(count),    64'd2);
    step();
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("fence.c2.mem_data",   mem_wr_data,      64'hB2);
    check("fence.c2.count",      64'(count),       64'd1);
    check("fence.c2.fence_done", 64'(fence_done),  64'd0);
    step();
    @(negedge clk);
    check("fence.c3.count",      64'(count),      64'd0);
    check("fence.c3.fence_done", 64'(fence_done), 64'd1);
    check("fence.c3.mem_wr_en",  64'(mem_wr_en),  64'd0);
    check("fence.c3.st_ready",   64'(st_ready),   64'd0);
    drain_req = 1'b0;
    step();
    @(negedge clk);
    check("fence.c4.fence_done", 64'(fence_done), 64'd0);
    check("fence.c4.st_ready",   64'(st_ready),   64'd1);
    check("fence.c4.count",      64'(count),      64'd0);
    step();

    // fence on an empty buffer: RUN, FENCE, then DONE
    begin
      int seen;
      seen = 99;
      drive(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (fence_done && seen == 99) begin
          seen = k;
          drain_req = 1'b0;
        end
        step();
      end
      check("fence_empty.latency", 64'(seen), 64'd2);
      drain_req = 1'b0;
    end

    // 6: reset while two entries are draining
    drive(1, 'hC0, 'hC1, 1, 'h100, 0); step();
    drive(1, 'hC8, 'hC9, 1, 'h100, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_mid.pre.count",     64'(count),     64'd2);
    check("rst_mid.pre.mem_wr_en", 64'(mem_wr_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.count",     64'(count),     64'd0);
    check("rst_mid.mem_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_mid.st_ready",  64'(st_ready),  64'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d.mem_wr_en", k), 64'(mem_wr_en), 64'd0);
      check($sformatf("rst_after%0d.count", k),     64'(count),     64'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
